// File: rtl/md5_stream_core_pkg.sv
// Shared MD5 definitions: initial chaining value, round constants, shift amounts,
// message-word schedule, FSM state encoding and the unroll-factor legality check.
package md5_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_FINAL,
        ST_OUT
    } state_e;

    localparam logic [31:0] IV_A = 32'h67452301;
    localparam logic [31:0] IV_B = 32'hefcdab89;
    localparam logic [31:0] IV_C = 32'h98badcfe;
    localparam logic [31:0] IV_D = 32'h10325476;

    localparam logic [31:0] K_TABLE [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] S_TABLE [64] = '{
        5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22, 5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20, 5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23, 5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21, 5'd6, 5'd10, 5'd15, 5'd21
    };

    // Word schedule per round; 4-bit arithmetic gives the mod-16 wrap for free.
    function automatic logic [3:0] msg_index(input logic [5:0] step);
        logic [3:0] i;
        i = step[3:0];
        case (step[5:4])
            2'd0:    return i;
            2'd1:    return i * 4'd5 + 4'd1;
            2'd2:    return i * 4'd3 + 4'd5;
            default: return i * 4'd7;
        endcase
    endfunction

    function automatic bit spc_legal(input int s);
        return (s == 1) || (s == 2) || (s == 4) || (s == 8) || (s == 16);
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/md5_stream_core_if.sv
// Block-in / digest-out valid-ready bus of the MD5 core; slave is the core side.
interface md5_stream_core_if;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
    logic         dig_valid;
    logic         dig_ready;
    logic [127:0] dig_data;

    modport slave (
        input  blk_valid, blk_data, blk_first, blk_last, dig_ready,
        output blk_ready, dig_valid, dig_data
    );

    modport master (
        output blk_valid, blk_data, blk_first, blk_last, dig_ready,
        input  blk_ready, dig_valid, dig_data
    );
endinterface

// File: rtl/md5_stream_core_step.sv
// One combinational MD5 step: (a,b,c,d) -> (d, b + rotl(a+f+K+M, s), b, c).
module md5_step (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [31:0] i_c,
    input  logic [31:0] i_d,
    input  logic [31:0] i_m,
    input  logic [31:0] i_k,
    input  logic [4:0]  i_s,
    input  logic [1:0]  i_round,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    output logic [31:0] o_c,
    output logic [31:0] o_d
);
    logic [31:0] w_f;
    logic [31:0] w_sum;
    logic [31:0] w_rot;

    always_comb begin
        // NOTE: default assignment first so every path drives w_f and no latch is inferred.
        w_f = 32'h0;
        case (i_round)
            2'd0: w_f = (i_b & i_c) | (~i_b & i_d);
            2'd1: w_f = (i_b & i_d) | (i_c & ~i_d);
            2'd2: w_f = i_b ^ i_c ^ i_d;
            2'd3: w_f = i_c ^ (i_b | ~i_d);
            default: w_f = 32'h0;
        endcase
    end

    assign w_sum = i_a + w_f + i_k + i_m;
    assign w_rot = (w_sum << i_s) | (w_sum >> (6'd32 - {1'b0, i_s}));

    assign o_a = i_d;
    assign o_b = i_b + w_rot;
    assign o_c = i_b;
    assign o_d = i_c;
endmodule

// File: rtl/md5_stream_core.sv
// MD5 compression engine with multi-block chaining, STEPS_PER_CYCLE steps per clock.
// Define MD5_BYTESWAP_EN to emit the canonical digest byte string instead of raw {D,C,B,A}.
module md5_stream_core
    import md5_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    md5_stream_core_if.slave bus,
    output logic             busy
);
    localparam int         S         = STEPS_PER_CYCLE;
    localparam logic [5:0] STEP_INC  = 6'(S);
    localparam logic [5:0] LAST_STEP = 6'(64 - S);

    if (!spc_legal(S)) begin : g_bad_steps
        $error("md5_stream_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    state_e       r_state;
    logic         r_blk_ready;
    logic         r_dig_valid;
    logic [127:0] r_dig_data;
    logic         r_last;
    logic [5:0]   r_step;
    logic [511:0] r_blk;
    logic [31:0]  r_a, r_b, r_c, r_d;
    logic [31:0]  r_ca, r_cb, r_cc, r_cd;
    logic         w_xfer;
    logic [127:0] w_digest;
    logic [31:0]  w_a [S+1];
    logic [31:0]  w_b [S+1];
    logic [31:0]  w_c [S+1];
    logic [31:0]  w_d [S+1];

    assign w_xfer = (r_state == ST_IDLE) && r_blk_ready && bus.blk_valid;
    assign w_a[0] = r_a;
    assign w_b[0] = r_b;
    assign w_c[0] = r_c;
    assign w_d[0] = r_d;

    for (genvar k = 0; k < S; k++) begin : g_step
        logic [5:0] w_idx;
        logic [3:0] w_g;
        assign w_idx = r_step + 6'(k);
        assign w_g   = msg_index(w_idx);
        md5_step u_step (
            .i_a(w_a[k]), .i_b(w_b[k]), .i_c(w_c[k]), .i_d(w_d[k]),
            .i_m(r_blk[{w_g, 5'd0} +: 32]),
            .i_k(K_TABLE[w_idx]),
            .i_s(S_TABLE[w_idx]),
            .i_round(w_idx[5:4]),
            .o_a(w_a[k+1]), .o_b(w_b[k+1]), .o_c(w_c[k+1]), .o_d(w_d[k+1])
        );
    end

`ifdef MD5_BYTESWAP_EN
    assign w_digest = {bswap32(r_ca), bswap32(r_cb), bswap32(r_cc), bswap32(r_cd)};
`else
    assign w_digest = {r_cd, r_cc, r_cb, r_ca};
`endif

    // NOTE: the block buffer has no reset; it is always loaded on transfer before it is read.
    always_ff @(posedge clk) begin
        if (w_xfer) r_blk <= bus.blk_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_blk_ready <= 1'b0;
            r_dig_valid <= 1'b0;
            r_dig_data  <= '0;
            r_last      <= 1'b0;
            r_step      <= '0;
            {r_a, r_b, r_c, r_d}     <= {IV_A, IV_B, IV_C, IV_D};
            {r_ca, r_cb, r_cc, r_cd} <= {IV_A, IV_B, IV_C, IV_D};
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                ST_IDLE: begin
                    if (w_xfer) begin
                        r_blk_ready <= 1'b0;
                        r_state     <= ST_COMPUTE;
                        r_step      <= '0;
                        r_last      <= bus.blk_last;
                        if (bus.blk_first) begin
                            {r_a, r_b, r_c, r_d}     <= {IV_A, IV_B, IV_C, IV_D};
                            {r_ca, r_cb, r_cc, r_cd} <= {IV_A, IV_B, IV_C, IV_D};
                        end else begin
                            {r_a, r_b, r_c, r_d} <= {r_ca, r_cb, r_cc, r_cd};
                        end
                    end else begin
                        r_blk_ready <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    {r_a, r_b, r_c, r_d} <= {w_a[S], w_b[S], w_c[S], w_d[S]};
                    r_step <= r_step + STEP_INC;
                    if (r_step == LAST_STEP) r_state <= ST_FINAL;
                end
                ST_FINAL: begin
                    r_ca <= r_ca + r_a;
                    r_cb <= r_cb + r_b;
                    r_cc <= r_cc + r_c;
                    r_cd <= r_cd + r_d;
                    if (r_last) begin
                        r_state <= ST_OUT;
                    end else begin
                        r_state     <= ST_IDLE;
                        r_blk_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    // First OUT cycle registers the digest; it then holds until taken.
                    if (!r_dig_valid) begin
                        r_dig_valid <= 1'b1;
                        r_dig_data  <= w_digest;
                    end else if (bus.dig_ready) begin
                        r_dig_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                        r_blk_ready <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign bus.blk_ready = r_blk_ready;
    assign bus.dig_valid = r_dig_valid;
    assign bus.dig_data  = r_dig_data;
endmodule

// File: tb/tb_md5_stream_core.sv
// Directed bench for md5_stream_core: four instances (1,2,4,16 steps/cycle) share one stimulus;
// instance 0 (1 step/cycle) is the main device under test.
module tb_md5_stream_core;
    localparam int NDUT = 4;
    localparam int SPC [NDUT] = '{1, 2, 4, 16};

`ifdef MD5_BYTESWAP_EN
    localparam logic [127:0] EXP_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam logic [127:0] EXP_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] EXP_A64   = 128'h014842d480b571495a4a0363793f7367;
`else
    localparam logic [127:0] EXP_EMPTY = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
    localparam logic [127:0] EXP_ABC   = 128'h727fe128_7d3f96d6_b04fd23c_98500190;
    localparam logic [127:0] EXP_A64   = 128'h67733f79_63034a5a_4971b580_d4424801;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         blk_valid = 1'b0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         dig_ready = 1'b0;
    logic [511:0] blk_data = '0;
    logic [NDUT-1:0] rdy_v, dv_v, busy_v;
    logic [127:0] dd_v [NDUT];
    logic [511:0] blk_empty, blk_abc, blk_a1, blk_a2;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        md5_stream_core_if u_if ();
        md5_stream_core #(.STEPS_PER_CYCLE(SPC[g])) u_dut (
            .clk(clk), .reset(reset), .bus(u_if.slave), .busy(busy_v[g])
        );
        assign u_if.blk_valid = blk_valid;
        assign u_if.blk_data  = blk_data;
        assign u_if.blk_first = blk_first;
        assign u_if.blk_last  = blk_last;
        assign u_if.dig_ready = dig_ready;
        assign rdy_v[g]       = u_if.blk_ready;
        assign dv_v[g]        = u_if.dig_valid;
        assign dd_v[g]        = u_if.dig_data;
    end

    task automatic send_block(input logic [511:0] d, input logic f, input logic l);
        int n = 0;
        while (!rdy_v[0] && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (rdy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL send_wait blk_ready=%b after %0d cycles, required 1", rdy_v[0], n);
        end else begin
            blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
            @(negedge clk);
            blk_valid = 1'b0;
        end
    endtask

    // Returns the number of clock edges after the transfer edge until dig_valid is seen.
    task automatic wait_digest(output logic [127:0] d, output int c);
        c = 0;
        while (!dv_v[0] && c < 300) begin @(negedge clk); c++; end
        d = dd_v[0];
    endtask

    task automatic take_digest();
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; blk_valid = 1'b0; dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (rdy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_blk_ready got %b exp 0", rdy_v[0]); end
        checks++; if (dv_v[0] !== 1'b0) begin errors++; $display("FAIL reset_dig_valid got %b exp 0", dv_v[0]); end
        checks++; if (dd_v[0] !== 128'h0) begin errors++; $display("FAIL reset_dig_data got %h exp 0", dd_v[0]); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_v[0]); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (rdy_v !== 4'hf) begin errors++; $display("FAIL reset_release_ready got %b exp 1111", rdy_v); end
    endtask

    task automatic test_sweep();
        int lat [NDUT];
        logic [127:0] dig [NDUT];
        logic [NDUT-1:0] seen = '0;
        int c = 0;
        for (int g = 0; g < NDUT; g++) begin lat[g] = -1; dig[g] = '0; end
        do_reset();
        send_block(blk_abc, 1'b1, 1'b1);
        while (seen != 4'hf && c < 100) begin
            @(negedge clk); c++;
            for (int g = 0; g < NDUT; g++)
                if (!seen[g] && dv_v[g]) begin seen[g] = 1'b1; lat[g] = c; dig[g] = dd_v[g]; end
        end
        for (int g = 0; g < NDUT; g++) begin
            checks++;
            if (dig[g] !== EXP_ABC) begin errors++; $display("FAIL sweep_digest S=%0d got %h exp %h", SPC[g], dig[g], EXP_ABC); end
            checks++;
            if (lat[g] != 64 / SPC[g] + 2) begin errors++; $display("FAIL sweep_latency S=%0d got %0d exp %0d", SPC[g], lat[g], 64 / SPC[g] + 2); end
        end
        take_digest();
    endtask

    task automatic test_empty();
        logic [127:0] d;
        int c;
        send_block(blk_empty, 1'b1, 1'b1);
        wait_digest(d, c);
        checks++; if (d !== EXP_EMPTY) begin errors++; $display("FAIL empty_digest got %h exp %h", d, EXP_EMPTY); end
        checks++; if (c != 66) begin errors++; $display("FAIL empty_latency got %0d exp 66", c); end
        take_digest();
        checks++; if (busy_v[0] !== 1'b0 || dv_v[0] !== 1'b0) begin errors++; $display("FAIL empty_after_take busy=%b dig_valid=%b exp 0 0", busy_v[0], dv_v[0]); end
    endtask

    task automatic test_hold();
        logic [127:0] d;
        int c = 0;
        int bad = 0;
        send_block(blk_a1, 1'b1, 1'b0);
        while (!rdy_v[0] && c < 300) begin @(negedge clk); c++; end
        checks++; if (c != 65) begin errors++; $display("FAIL hold_block_period ready after %0d exp 65", c); end
        checks++; if (dv_v[0] !== 1'b0) begin errors++; $display("FAIL hold_no_digest_mid got %b exp 0", dv_v[0]); end
        send_block(blk_a2, 1'b0, 1'b1);
        wait_digest(d, c);
        checks++; if (c != 66) begin errors++; $display("FAIL hold_latency got %0d exp 66", c); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dd_v[0] !== d || rdy_v[0] !== 1'b0 || dv_v[0] !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL hold_stable unstable cycles got %0d exp 0", bad); end
        checks++; if (d !== EXP_A64) begin errors++; $display("FAIL hold_digest got %h exp %h", d, EXP_A64); end
        take_digest();
        checks++; if (rdy_v[0] !== 1'b1 || dv_v[0] !== 1'b0) begin errors++; $display("FAIL hold_after_take ready=%b dig_valid=%b exp 1 0", rdy_v[0], dv_v[0]); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d;
        int c = 0;
        send_block(blk_a1, 1'b1, 1'b0);
        while (!rdy_v[0] && c < 300) begin @(negedge clk); c++; end
        send_block(blk_a2, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy_v[0]); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (busy_v[0] !== 1'b0 || dv_v[0] !== 1'b0 || rdy_v[0] !== 1'b0) begin
            errors++; $display("FAIL mid_reset_state busy=%b dig_valid=%b ready=%b exp 0 0 0", busy_v[0], dv_v[0], rdy_v[0]);
        end
        reset = 1'b0;
        @(negedge clk);
        send_block(blk_empty, 1'b0, 1'b1);
        wait_digest(d, c);
        checks++; if (c != 66) begin errors++; $display("FAIL mid_latency got %0d exp 66", c); end
        checks++; if (d !== EXP_EMPTY) begin errors++; $display("FAIL mid_digest got %h exp %h", d, EXP_EMPTY); end
        take_digest();
    endtask

    task automatic test_back_to_back();
        logic [127:0] got [2];
        int at [2];
        int n = 0;
        int c = 0;
        bit seen_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin got[i] = '0; at[i] = -1; end
        dig_ready = 1'b1;
        while (!rdy_v[0] && c < 300) begin @(negedge clk); c++; end
        blk_data = blk_abc; blk_first = 1'b1; blk_last = 1'b1; blk_valid = 1'b1;
        @(negedge clk);
        blk_data = blk_empty;
        c = 0;
        while (n < 2 && c < 400) begin
            @(negedge clk); c++;
            if (dv_v[0]) begin got[n] = dd_v[0]; at[n] = c; n++; end
            if (n == 1 && rdy_v[0]) seen_rdy = 1'b1;
            else if (seen_rdy && busy_v[0]) blk_valid = 1'b0;
        end
        blk_valid = 1'b0;
        dig_ready = 1'b0;
        checks++; if (got[0] !== EXP_ABC) begin errors++; $display("FAIL b2b_first_digest got %h exp %h", got[0], EXP_ABC); end
        checks++; if (got[1] !== EXP_EMPTY) begin errors++; $display("FAIL b2b_second_digest got %h exp %h", got[1], EXP_EMPTY); end
        checks++; if (at[0] != 66) begin errors++; $display("FAIL b2b_first_time got %0d exp 66", at[0]); end
        checks++; if (at[1] != 134) begin errors++; $display("FAIL b2b_second_time got %0d exp 134", at[1]); end
        @(negedge clk);
    endtask

    initial begin
        blk_empty = '0; blk_empty[31:0] = 32'h00000080;
        blk_abc = '0; blk_abc[31:0] = 32'h80636261; blk_abc[479:448] = 32'h00000018;
        blk_a1 = {16{32'h61616161}};
        blk_a2 = '0; blk_a2[31:0] = 32'h00000080; blk_a2[479:448] = 32'h00000200;
        test_reset();
        test_sweep();
        test_empty();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
